// File: rtl/ring_ctrl_pkg.sv
// ring_ctrl_pkg: shared types and constants for the ring step controller.
//   state_t      : run/pause FSM state
//   RING_LEN_DEF : default ring length
//   DIR_LEFT     : direction encoding for a left shift (pos counts up)
package ring_ctrl_pkg;
   typedef enum logic {ST_STOP, ST_RUN} state_t;
   localparam int   RING_LEN_DEF = 18;
   localparam logic DIR_LEFT     = 1'b1;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchronizer plus stability counter for the direction switch.
//   clk     : system clock
//   rst_n   : async reset, active low
//   sw_raw  : raw (asynchronous) switch input
//   deb_dir : debounced direction, resets to DIR_LEFT
module sw_debounce import ring_ctrl_pkg::*; #(
   parameter int DEB = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic deb_dir
);
   localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;

   logic [1:0]    sw_q;
   logic          sw_s;
   logic [CW-1:0] cnt;

   // synchronizer resets to 1 so a held-left switch causes no spurious count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sw_q <= 2'b11;
      else        sw_q <= {sw_q[0], sw_raw};
   end

   assign sw_s = sw_q[1];

   // cnt tracks consecutive cycles of disagreement; DEB of them commit the change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         deb_dir <= DIR_LEFT;
      end else if (sw_s == deb_dir) begin
         cnt <= '0;
      end else if (cnt == CW'(DEB - 1)) begin
         deb_dir <= sw_s;
         cnt     <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/ring_step_ctrl.sv
// ring_step_ctrl: step/direction controller feeding the ring counter stage.
//   clk    : system clock
//   res    : async reset, active low
//   sw_raw : raw direction switch (1 = left / pos up)
//   run    : raw run enable (1 = stepping)
//   step_o : one-cycle step enable for the ring stage
//   dir_o  : direction qualifying step_o
//   pos_o  : binary index of the ring's hot bit
//   wrap_o : one-cycle pulse on a pos_o wrap in either direction
module ring_step_ctrl import ring_ctrl_pkg::*; #(
   parameter int DIV      = 25_000_000,
   parameter int DEB      = 500_000,
   parameter int RING_LEN = RING_LEN_DEF,
   parameter int POS_W    = 5
) (
   input  logic             clk,
   input  logic             res,
   input  logic             sw_raw,
   input  logic             run,
   output logic             step_o,
   output logic             dir_o,
   output logic [POS_W-1:0] pos_o,
   output logic             wrap_o
);
   localparam int               PW   = $clog2(DIV);
   localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);
   localparam logic [POS_W-1:0] LAST = POS_W'(RING_LEN - 1);

   logic [1:0]    run_q;
   logic          run_s;
   logic          deb_dir;
   state_t        state, state_nx;
   logic [PW-1:0] psc, psc_nx;
   logic          step_nx;

   sw_debounce #(.DEB(DEB)) u_deb (
      .clk     (clk),
      .rst_n   (res),
      .sw_raw  (sw_raw),
      .deb_dir (deb_dir)
   );

   always_ff @(posedge clk or negedge res) begin
      if (!res) run_q <= 2'b00;
      else      run_q <= {run_q[0], run};
   end

   assign run_s = run_q[1];

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state <= ST_STOP;
         psc   <= '0;
      end else begin
         state <= state_nx;
         psc   <= psc_nx;
      end
   end

   // prescaler only advances in RUN while run_s is high; a pause keeps its phase
   always_comb begin
      state_nx = state;
      psc_nx   = psc;
      step_nx  = 1'b0;
      case (state)
         ST_STOP: if (run_s) state_nx = ST_RUN;
         ST_RUN: begin
            if (!run_s) begin
               state_nx = ST_STOP;
            end else if (psc == PMAX) begin
               psc_nx  = '0;
               step_nx = 1'b1;
            end else begin
               psc_nx = psc + PW'(1);
            end
         end
         default: state_nx = ST_STOP;
      endcase
   end

   // dir_o, pos_o and wrap_o all move on the same edge that raises step_o
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         step_o <= 1'b0;
         dir_o  <= DIR_LEFT;
         pos_o  <= '0;
         wrap_o <= 1'b0;
      end else begin
         step_o <= step_nx;
         wrap_o <= 1'b0;
         if (step_nx) begin
            dir_o <= deb_dir;
            if (deb_dir == DIR_LEFT) begin
               if (pos_o == LAST) begin
                  pos_o  <= '0;
                  wrap_o <= 1'b1;
               end else begin
                  pos_o <= pos_o + POS_W'(1);
               end
            end else begin
               if (pos_o == '0) begin
                  pos_o  <= LAST;
                  wrap_o <= 1'b1;
               end else begin
                  pos_o <= pos_o - POS_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_ring_step_ctrl.sv
// tb_ring_step_ctrl: directed + random stimulus against a cycle-level reference
// model built from delay lines, a disagreement run-length and an active-cycle count.
module tb_ring_step_ctrl;
   localparam int DIV = 4, DEB = 3, RL = 18, PW = 5;

   logic          clk = 1'b0;
   logic          res, sw_raw, run;
   logic          step_o, dir_o, wrap_o;
   logic [PW-1:0] pos_o;

   always #5 clk = ~clk;

   ring_step_ctrl #(.DIV(DIV), .DEB(DEB), .RING_LEN(RL), .POS_W(PW)) dut (
      .clk    (clk),
      .res    (res),
      .sw_raw (sw_raw),
      .run    (run),
      .step_o (step_o),
      .dir_o  (dir_o),
      .pos_o  (pos_o),
      .wrap_o (wrap_o)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   bit sw_dl[$];
   bit run_dl[$];
   bit m_deb, m_state, m_step, m_dir, m_wrap;
   int m_diff, m_active, m_pos;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sw_dl    = {1'b1, 1'b1};
      run_dl   = {1'b0, 1'b0};
      m_deb    = 1'b1;
      m_diff   = 0;
      m_state  = 1'b0;
      m_active = 0;
      m_step   = 1'b0;
      m_dir    = 1'b1;
      m_pos    = 0;
      m_wrap   = 1'b0;
   endtask

   // one clock edge of the reference behaviour, from pre-edge values
   task automatic model_edge();
      bit sw_s, run_s, active;
      sw_s   = sw_dl[0];
      run_s  = run_dl[0];
      // the controller is "running" iff the synced run was high on the previous edge
      active = m_state && run_s;
      m_step = active && ((m_active % DIV) == DIV - 1);
      m_wrap = 1'b0;
      if (m_step) begin
         m_dir = m_deb;
         if (m_deb) begin
            m_pos  = (m_pos + 1) % RL;
            m_wrap = (m_pos == 0);
         end else begin
            m_wrap = (m_pos == 0);
            m_pos  = (m_pos + RL - 1) % RL;
         end
      end
      if (active) m_active++;
      m_state = run_s;
      if (sw_s != m_deb) begin
         m_diff++;
         if (m_diff == DEB) begin
            m_deb  = sw_s;
            m_diff = 0;
         end
      end else begin
         m_diff = 0;
      end
      sw_dl  = {sw_dl[1], sw_raw};
      run_dl = {run_dl[1], run};
   endtask

   task automatic tick();
      @(posedge clk);
      if (res) model_edge();
      #1;
      chk("step_o", {31'd0, step_o}, {31'd0, m_step});
      chk("dir_o",  {31'd0, dir_o},  {31'd0, m_dir});
      chk("wrap_o", {31'd0, wrap_o}, {31'd0, m_wrap});
      chk("pos_o",  {27'd0, pos_o},  m_pos);
   endtask

   initial begin
      int n, steps, wraps, bad_dir, pre_pos;
      res = 1'b1; sw_raw = 1'b1; run = 1'b0;
      model_reset();
      #2 res = 1'b0;
      #1;
      chk("rst_step", {31'd0, step_o}, 0);
      chk("rst_dir",  {31'd0, dir_o},  1);
      chk("rst_pos",  {27'd0, pos_o},  0);
      chk("rst_wrap", {31'd0, wrap_o}, 0);
      repeat (3) tick();
      res = 1'b1;

      // first step after release: 2 sync + 1 FSM + DIV prescaler cycles
      run = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!step_o && n < 20);
      chk("first_step_lat", n, 2 + 1 + DIV);
      chk("first_pos", {27'd0, pos_o}, 1);

      // left run to the 18th step; flip switch right after step 17 so the
      // following step is the first one going right
      steps = 1; wraps = 0; n = 0;
      while (steps < RL && n < 200) begin
         tick(); n++;
         if (step_o) begin
            steps++;
            if (steps == RL - 1) sw_raw = 1'b0;
         end
         if (wrap_o) wraps++;
      end
      chk("left_steps", steps, RL);
      chk("left_wraps", wraps, 1);
      chk("left_wrap_pos", {27'd0, pos_o}, 0);

      n = 0;
      do begin tick(); n++; end while (!step_o && n < 20);
      chk("right_dir", {31'd0, dir_o}, 0);
      chk("right_pos", {27'd0, pos_o}, RL - 1);
      chk("right_wrap", {31'd0, wrap_o}, 1);
      n = 0;
      do begin tick(); n++; end while (!step_o && n < 20);
      chk("right_pos2", {27'd0, pos_o}, RL - 2);
      chk("right_wrap2", {31'd0, wrap_o}, 0);

      // back to left, then a 2-cycle low glitch that must be ignored
      sw_raw = 1'b1;
      repeat (12) tick();
      n = 0;
      do begin tick(); n++; end while (!step_o && n < 20);
      sw_raw = 1'b0;
      repeat (2) tick();
      sw_raw = 1'b1;
      bad_dir = 0; steps = 0;
      repeat (16) begin
         tick();
         if (step_o) begin
            steps++;
            if (!dir_o) bad_dir++;
         end
      end
      chk("glitch_steps", steps, 4);
      chk("glitch_dir", bad_dir, 0);

      // pause with the prescaler held at 2, then resume
      n = 0;
      do begin tick(); n++; end while (!step_o && n < 20);
      run = 1'b0;
      pre_pos = pos_o;
      steps = 0;
      repeat (12) begin tick(); if (step_o) steps++; end
      chk("pause_steps", steps, 0);
      chk("pause_pos", {27'd0, pos_o}, pre_pos);
      run = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!step_o && n < 20);
      // 2 sync + 1 FSM re-entry + 2 remaining prescaler counts (2 -> 3 -> step)
      chk("resume_lat", n, 5);
      chk("resume_pos", {27'd0, pos_o}, (pre_pos + 1) % RL);

      // randomized run/switch activity
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(39) == 0) run = ~run;
         if ($urandom_range(11) == 0) sw_raw = ~sw_raw;
         tick();
      end

      // async reset in the middle of a count at pos 7
      run = 1'b1; sw_raw = 1'b1;
      n = 0;
      do begin tick(); n++; end while (pos_o != 7 && n < 600);
      chk("reach_pos7", {27'd0, pos_o}, 7);
      tick(); tick();
      #2 res = 1'b0;
      #1;
      chk("mid_rst_step", {31'd0, step_o}, 0);
      chk("mid_rst_dir",  {31'd0, dir_o},  1);
      chk("mid_rst_pos",  {27'd0, pos_o},  0);
      chk("mid_rst_wrap", {31'd0, wrap_o}, 0);
      model_reset();
      repeat (3) tick();
      res = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!step_o && n < 20);
      chk("restart_lat", n, 2 + 1 + DIV);
      chk("restart_pos", {27'd0, pos_o}, 1);
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
